// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two RAM requesters (core C, secondary V), the
// single-port RAM and the arbiter. The master side is the environment
// (requesters plus RAM read data); the slave side is the arbiter itself.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ack;
  logic [DATA_W-1:0] c_rdata;

  logic              v_req;
  logic              v_we;
  logic [ADDR_W-1:0] v_addr;
  logic [DATA_W-1:0] v_wdata;
  logic              v_ack;
  logic [DATA_W-1:0] v_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output v_req, v_we, v_addr, v_wdata,
    output mem_din,
    input  c_ack, c_rdata, v_ack, v_rdata,
    input  mem_addr, mem_dout, mem_we
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  v_req, v_we, v_addr, v_wdata,
    input  mem_din,
    output c_ack, c_rdata, v_ack, v_rdata,
    output mem_addr, mem_dout, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the CPU core (C)
// and a secondary reader/writer (V). Each access runs IDLE -> ACCESS -> DONE;
// reads hold the address READ_LAT cycles before sampling mem_din.
module mem_port_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_WAIT = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state, state_nxt;
  logic              start, finish, sel_v;
  logic              grant_v;   // winner of the transaction in flight
  logic              last_v;    // last grant went to V
  logic              is_wr;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  // Winner's request fields; the loser's inputs never reach the RAM.
  always_comb begin
    sel_addr  = sel_v ? bus.v_addr  : bus.c_addr;
    sel_wdata = sel_v ? bus.v_wdata : bus.c_wdata;
    sel_we    = sel_v ? bus.v_we    : bus.c_we;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and arbitration: on a tie the port that did not win last time goes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    sel_v     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.c_req || bus.v_req) begin
          start     = 1'b1;
          sel_v     = bus.v_req && (!bus.c_req || !last_v);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM drive, wait counter, grant history; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_addr <= '0;
      bus.mem_dout <= '0;
      bus.mem_we   <= 1'b0;
      grant_v      <= 1'b0;
      last_v       <= 1'b1;
      is_wr        <= 1'b0;
      cnt          <= '0;
    end else if (start) begin
      bus.mem_addr <= sel_addr;
      bus.mem_dout <= sel_wdata;
      bus.mem_we   <= sel_we;
      grant_v      <= sel_v;
      last_v       <= sel_v;
      is_wr        <= sel_we;
      cnt          <= sel_we ? '0 : RD_WAIT;
    end else if (state == ACCESS) begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      if (finish)    bus.mem_we <= 1'b0;
    end
  end

  // Per-port read data capture and one-cycle completion pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.c_rdata <= '0;
      bus.v_rdata <= '0;
      bus.c_ack   <= 1'b0;
      bus.v_ack   <= 1'b0;
    end else begin
      bus.c_ack <= finish && !grant_v;
      bus.v_ack <= finish &&  grant_v;
      if (finish && !is_wr) begin
        if (grant_v) bus.v_rdata <= bus.mem_din;
        else         bus.c_rdata <= bus.mem_din;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a READ_LAT=2 instance exercised
// through directed transactions, plus a READ_LAT=1 instance for a V read.
module tb_mem_port_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(ifa));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(ifb));

  function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
    if (a == AW'(5)) return 16'h1234;
    return DW'(a) ^ 16'hA5C3;
  endfunction

  // RAM models: one registered stage for READ_LAT=2, combinational for READ_LAT=1.
  always @(posedge clock) ifa.mem_din <= ram_val(ifa.mem_addr);
  assign ifb.mem_din = ram_val(ifb.mem_addr);

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit             pv;
    bit             rd;
    logic [DW-1:0]  data;
  } sb_t;
  sb_t sb[$];
  int  ack_cyc[$];
  int  ack_cnt = 0;

  bit            exp_last_v;
  logic [DW-1:0] exp_c_rd, exp_v_rd;

  // Scoreboard: every ack of dut_a must match the oldest expected grant.
  always @(posedge clock) begin
    #1;
    if (reset_n && (ifa.c_ack || ifa.v_ack)) begin
      sb_t e;
      ack_cnt++;
      ack_cyc.push_back(cyc);
      chk("ack_onehot", 32'(ifa.c_ack & ifa.v_ack), 32'd0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_port", 32'(ifa.v_ack), 32'(e.pv));
        if (e.rd) chk("rdata", 32'(e.pv ? ifa.v_rdata : ifa.c_rdata), 32'(e.data));
      end
    end
  end

  task automatic push_txn(input bit pv, input bit we, input logic [AW-1:0] a);
    sb.push_back('{pv, !we, ram_val(a)});
    if (!we) begin
      if (pv) exp_v_rd = ram_val(a);
      else    exp_c_rd = ram_val(a);
    end
    exp_last_v = pv;
  endtask

  // One transaction on a single port of dut_a with latency and bus checks.
  task automatic run_single(input bit pv, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input int exp_lat);
    int n;
    bit seen;
    @(negedge clock);
    if (pv) begin
      ifa.v_req = 1'b1; ifa.v_we = we; ifa.v_addr = a; ifa.v_wdata = wd;
    end else begin
      ifa.c_req = 1'b1; ifa.c_we = we; ifa.c_addr = a; ifa.c_wdata = wd;
    end
    push_txn(pv, we, a);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clock);
      n++;
      chk("mem_we", 32'(ifa.mem_we), 32'(we && n == 1));
      if (n == 1) begin
        chk("mem_addr", 32'(ifa.mem_addr), 32'(a));
        if (we) chk("mem_dout", 32'(ifa.mem_dout), 32'(wd));
      end
      chk("other_ack", 32'(pv ? ifa.c_ack : ifa.v_ack), 32'd0);
      if (pv ? ifa.v_ack : ifa.c_ack) begin
        seen = 1'b1;
        chk("latency", 32'(n), 32'(exp_lat));
        ifa.c_req = 1'b0;
        ifa.v_req = 1'b0;
      end
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("other_rdata", 32'(pv ? ifa.c_rdata : ifa.v_rdata), 32'(pv ? exp_c_rd : exp_v_rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, n_ack;
    bit w;
    reset_n = 1'b0;
    ifa.c_req = 0; ifa.c_we = 0; ifa.c_addr = '0; ifa.c_wdata = '0;
    ifa.v_req = 0; ifa.v_we = 0; ifa.v_addr = '0; ifa.v_wdata = '0;
    ifb.c_req = 0; ifb.c_we = 0; ifb.c_addr = '0; ifb.c_wdata = '0;
    ifb.v_req = 0; ifb.v_we = 0; ifb.v_addr = '0; ifb.v_wdata = '0;
    exp_last_v = 1'b1; exp_c_rd = '0; exp_v_rd = '0;
    repeat (3) @(negedge clock);
    chk("rst_mem_we",   32'(ifa.mem_we),   32'd0);
    chk("rst_mem_addr", 32'(ifa.mem_addr), 32'd0);
    chk("rst_mem_dout", 32'(ifa.mem_dout), 32'd0);
    chk("rst_acks",     32'({ifa.c_ack, ifa.v_ack}), 32'd0);
    chk("rst_rdata",    32'({ifa.c_rdata, ifa.v_rdata}), 32'd0);
    reset_n = 1'b1;

    // Single-port transactions, including all-ones address/data.
    run_single(1'b0, 1'b1, AW'(9216), 16'h00AA, 2);
    run_single(1'b0, 1'b0, AW'(5), 16'h0000, 3);
    run_single(1'b1, 1'b1, AW'(15'h7FFF), 16'hFFFF, 2);
    run_single(1'b1, 1'b0, AW'(15'h7FFF), 16'h0000, 3);

    // Reset in the ACCESS cycle of a write aborts it.
    @(negedge clock);
    ifa.c_req = 1'b1; ifa.c_we = 1'b1; ifa.c_addr = AW'(100); ifa.c_wdata = 16'hBEEF;
    base = ack_cnt;
    @(negedge clock);
    chk("abort_we_before", 32'(ifa.mem_we), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_we_async", 32'(ifa.mem_we), 32'd0);
    ifa.c_req = 1'b0;
    exp_last_v = 1'b1; exp_c_rd = '0; exp_v_rd = '0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("abort_no_ack",  32'(ack_cnt - base), 32'd0);
    chk("abort_addr",    32'(ifa.mem_addr), 32'd0);
    chk("abort_dout",    32'(ifa.mem_dout), 32'd0);
    chk("abort_rdata_c", 32'(ifa.c_rdata), 32'd0);
    chk("abort_rdata_v", 32'(ifa.v_rdata), 32'd0);

    // Simultaneous first requests after reset: core wins the tie.
    @(negedge clock);
    ifa.c_req = 1'b1; ifa.c_we = 1'b0; ifa.c_addr = AW'(1);
    ifa.v_req = 1'b1; ifa.v_we = 1'b0; ifa.v_addr = AW'(2);
    w = !exp_last_v;
    push_txn(w, 1'b0, w ? AW'(2) : AW'(1));
    push_txn(!w, 1'b0, w ? AW'(1) : AW'(2));
    base = ack_cnt;
    n = 0;
    while ((ifa.c_req || ifa.v_req) && n < 20) begin
      @(negedge clock);
      n++;
      if (ifa.c_ack) ifa.c_req = 1'b0;
      if (ifa.v_ack) ifa.v_req = 1'b0;
    end
    chk("pair_acks", 32'(ack_cnt - base), 32'd2);
    if (ack_cyc.size() >= 2) chk("pair_gap", 32'(ack_cyc[$] - ack_cyc[$-1]), 32'd4);

    // Both ports held high: grants alternate with no repeats.
    @(negedge clock);
    ifa.c_req = 1'b1; ifa.c_we = 1'b0; ifa.c_addr = AW'(3);
    ifa.v_req = 1'b1; ifa.v_we = 1'b0; ifa.v_addr = AW'(4);
    for (int i = 0; i < 6; i++) begin
      w = !exp_last_v;
      push_txn(w, 1'b0, w ? AW'(4) : AW'(3));
    end
    base = ack_cnt;
    n = 0;
    while (ifa.c_req && n < 60) begin
      @(negedge clock);
      n++;
      if (ack_cnt >= base + 6) begin
        ifa.c_req = 1'b0;
        ifa.v_req = 1'b0;
      end
    end
    ifa.c_req = 1'b0;
    ifa.v_req = 1'b0;
    repeat (6) @(negedge clock);
    n_ack = ack_cnt - base;
    chk("rr_acks", 32'(n_ack), 32'd6);
    if (ack_cyc.size() >= 6)
      for (int i = ack_cyc.size() - 5; i < ack_cyc.size(); i++)
        chk("rr_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // READ_LAT=1 instance, V read.
    @(negedge clock);
    ifb.v_req = 1'b1; ifb.v_we = 1'b0; ifb.v_addr = AW'(7);
    n = 0;
    w = 1'b0;
    while (!w && n < 12) begin
      @(negedge clock);
      n++;
      chk("b_c_ack", 32'(ifb.c_ack), 32'd0);
      if (ifb.v_ack) begin
        w = 1'b1;
        chk("b_latency", 32'(n), 32'd2);
        chk("b_rdata", 32'(ifb.v_rdata), 32'(ram_val(AW'(7))));
        ifb.v_req = 1'b0;
      end
    end
    chk("b_ack_seen", 32'(w), 32'd1);
    chk("b_c_rdata", 32'(ifb.c_rdata), 32'd0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters:
  - the CPU core (port C);
  - a secondary master such as a display or DMA reader (port V).
- Each requester uses a req/ack handshake. The block drives the RAM address, write data and write enable, inserts the RAM read wait states, and returns read data per requester.
- Arbitration is round-robin, so neither master starves.

Parameters:
- ADDR_W, 15, RAM address width.
- DATA_W, 16, RAM data width.
- READ_LAT, 2, cycles the address is held before mem_din is sampled (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- c_req  in  1  core request; held until c_ack.
- c_we  in  1  core write(1)/read(0); stable while c_req.
- c_addr  in  ADDR_W  core address; stable while c_req.
- c_wdata  in  DATA_W  core write data; stable while c_req.
- c_ack  out  1  one-cycle completion pulse to core.
- c_rdata  out  DATA_W  core read data, valid when c_ack on a read; held otherwise.
- v_req, v_we, v_addr, v_wdata, v_ack, v_rdata: same as the c_ group, for port V.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_dout  out  DATA_W  RAM write data (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_din  in  DATA_W  RAM read data.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE;
  - mem_we=0, mem_addr=0, mem_dout=0;
  - c_ack=v_ack=0, c_rdata=v_rdata=0;
  - wait counter=0;
  - last_grant=V, so the core wins the first tie.
  - Reset mid-transaction aborts it: no ack is issued and mem_we drops immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - mem_we=0; mem_addr and mem_dout hold their previous values.
  - At a clock edge with any req high, select the winner:
    - only one requester active → that one;
    - both active → the one not equal to last_grant.
  - On selection:
    - latch the winner's addr/we/wdata into mem_addr/mem_we/mem_dout;
    - set last_grant to the winner;
    - load wait counter = READ_LAT-1 for a read, 0 for a write;
    - go to ACCESS.
- ACCESS:
  - mem_addr and mem_dout are held.
  - A write keeps mem_we=1 for exactly this one cycle.
  - A read keeps mem_we=0 and decrements the counter each cycle.
  - When counter==0 at an edge:
    - for a read, capture mem_din into the winner's rdata register;
    - clear mem_we;
    - go to DONE.
- DONE:
  - The winner's ack=1 for exactly one cycle; the other ack stays 0.
  - At the next edge go to IDLE.
  - req is not sampled in DONE.
  - A requester still holding req in the following IDLE cycle starts a new transaction.
- Latency from the edge sampling req in IDLE to the ack cycle:
  - write: 2 cycles;
  - read: READ_LAT+1 cycles (3 at default).
- Idle-to-idle occupancy:
  - write: 3 cycles;
  - read: READ_LAT+2 cycles.
- Fairness: with both requesters continuously requesting, grants alternate C,V,C,V. A waiting requester is delayed by at most one transaction of the other.
- Only the granted requester's rdata updates; the other rdata is held.
- A requester dropping req while not granted simply withdraws.
- Dropping req while granted is illegal; the transaction still completes and acks.
- Inputs of the non-granted port are ignored.
- Width rules:
  - addresses and data pass through unmodified;
  - the counter is sized for READ_LAT-1;
  - no wrap-around arithmetic on addresses.

Test Plan:
- Reset, then core write: c_req=1, c_we=1, c_addr=9216, c_wdata=16'h00AA.
  - mem_we=1 for exactly one cycle with mem_addr=9216, mem_dout=16'h00AA.
  - c_ack pulses 2 cycles after the sampling edge; v_ack stays 0.
- Core read with a RAM model returning 16'h1234 at address 5 after 2 cycles.
  - c_ack pulses 3 cycles after the sampling edge with c_rdata=16'h1234.
  - mem_we=0 throughout; v_rdata unchanged.
- Simultaneous first requests, core read addr 1 and V read addr 2.
  - Core is granted first and its ack comes first.
  - V is granted in the next IDLE; acks are separated by READ_LAT+2 cycles.
- Both requesters held high for 6 transactions.
  - Grant order is C,V,C,V,C,V.
  - No back-to-back grants to the same port.
- Assert reset_n=0 during ACCESS of a write.
  - mem_we falls asynchronously; no ack is issued.
  - After release, state=IDLE and mem_addr=0.
- READ_LAT=1 instance, V read.
  - v_ack pulses 2 cycles after the sampling edge with the captured data.
